// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave core: register offsets,
// rd_data bit positions and the engine state encoding.
package spi_slave_pkg;

  localparam logic [1:0] REG_CLR  = 2'b00;
  localparam logic [1:0] REG_CTRL = 2'b10;
  localparam logic [1:0] REG_TX   = 2'b11;

  localparam int unsigned RD_RX_VALID  = 8;
  localparam int unsigned RD_OVERRUN   = 9;
  localparam int unsigned RD_TX_LOADED = 10;
  localparam int unsigned RD_BUSY      = 11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_engine.sv
// SPI pin engine: synchronizers, SCLK edge detection, frame FSM and shift
// registers. Reports loads and completed bytes to the register block.
module spi_slave_engine
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk_in,
  input  logic       ss_n_in,
  input  logic       mosi,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] load_byte,
  output logic       load_req,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       miso,
  output logic       miso_en,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shreg;
  logic [7:0]             r_tx_shreg;
  logic                   r_byte_done;
  logic [7:0]             r_byte_data;

  logic w_sclk_s, w_ss_s, w_mosi_s;
  logic w_lead, w_trail, w_sample, w_shift;
  logic w_start, w_active;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level cpol; trailing edge returns to it.
  assign w_lead   = (w_sclk_s != cpol) && (r_sclk_d == cpol);
  assign w_trail  = (w_sclk_s == cpol) && (r_sclk_d != cpol);
  assign w_sample = cpha ? w_trail : w_lead;
  assign w_shift  = cpha ? w_lead  : w_trail;

  assign w_start  = (r_state == IDLE) && !w_ss_s;
  assign w_active = (r_state == ACTIVE) && !w_ss_s;
  assign load_req = (w_start && !cpha) || (w_active && w_shift && (r_bit_cnt == 3'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk_in};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_shreg  <= '0;
      r_tx_shreg  <= '1;
      r_byte_done <= 1'b0;
      r_byte_data <= '0;
    end else begin
      r_byte_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= ACTIVE;
            r_bit_cnt  <= '0;
            r_rx_shreg <= '0;
            if (load_req) r_tx_shreg <= load_byte;
          end
        end
        ACTIVE: begin
          if (w_ss_s) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end else if (w_sample) begin
            r_rx_shreg <= {r_rx_shreg[5:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_byte_done <= 1'b1;
              r_byte_data <= {r_rx_shreg, w_mosi_s};
            end
          end else if (w_shift) begin
            if (load_req) r_tx_shreg <= load_byte;
            else          r_tx_shreg <= {r_tx_shreg[6:0], 1'b1};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign byte_done = r_byte_done;
  assign byte_data = r_byte_data;
  assign miso      = r_tx_shreg[7];
  assign miso_en   = ~w_ss_s;
  assign busy      = ~w_ss_s;

endmodule

// File: rtl/spi_slave_core.sv
// MMIO-slot SPI slave: register map, TX/RX holding registers and status
// flags around the spi_slave_engine pin engine.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_clk_in,
  input  logic        ss_n_in,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_en
);

  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic [7:0] r_tx_data;
  logic       r_tx_loaded;
  logic       r_cpol;
  logic       r_cpha;

  logic       w_wr;
  logic       w_load_req;
  logic       w_byte_done;
  logic [7:0] w_byte_data;
  logic [7:0] w_load_byte;
  logic       w_busy;
  logic       w_unused;

  assign w_wr        = write & cs;
  assign w_load_byte = r_tx_loaded ? r_tx_data : 8'hFF;
  assign w_unused    = ^{read, reg_addr[4:2], wr_data[31:8]};

  spi_slave_engine #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_engine (
    .clk       (clk),
    .reset     (reset),
    .spi_clk_in(spi_clk_in),
    .ss_n_in   (ss_n_in),
    .mosi      (mosi),
    .cpol      (r_cpol),
    .cpha      (r_cpha),
    .load_byte (w_load_byte),
    .load_req  (w_load_req),
    .byte_done (w_byte_done),
    .byte_data (w_byte_data),
    .miso      (miso),
    .miso_en   (miso_en),
    .busy      (w_busy)
  );

  // Later assignments win: byte completion overrides a clear, and a TX
  // write overrides the load's clear of tx_loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_loaded <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
    end else begin
      if (w_wr && (reg_addr[1:0] == REG_CLR)) begin
        if (wr_data[0]) r_rx_valid <= 1'b0;
        if (wr_data[1]) r_overrun  <= 1'b0;
      end
      if (w_byte_done) begin
        r_rx_data  <= w_byte_data;
        r_rx_valid <= 1'b1;
        if (r_rx_valid) r_overrun <= 1'b1;
      end
      if (w_wr && (reg_addr[1:0] == REG_CTRL) && !w_busy) begin
        r_cpol <= wr_data[0];
        r_cpha <= wr_data[1];
      end
      if (w_load_req) r_tx_loaded <= 1'b0;
      if (w_wr && (reg_addr[1:0] == REG_TX)) begin
        r_tx_data   <= wr_data[7:0];
        r_tx_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data               = '0;
    rd_data[7:0]          = r_rx_data;
    rd_data[RD_RX_VALID]  = r_rx_valid;
    rd_data[RD_OVERRUN]   = r_overrun;
    rd_data[RD_TX_LOADED] = r_tx_loaded;
    rd_data[RD_BUSY]      = w_busy;
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed self-checking bench for spi_slave_core acting as an SPI master
// across all modes, aborts, overrun and register-write corner cases.
module tb_spi_slave_core;

  localparam int HALF = 8;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        spi_clk_in;
  logic        ss_n_in;
  logic        mosi;
  logic        miso;
  logic        miso_en;

  int checks;
  int failures;
  logic m_cpol;
  logic m_cpha;

  spi_slave_core #(
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .spi_clk_in(spi_clk_in),
    .ss_n_in   (ss_n_in),
    .mosi      (mosi),
    .miso      (miso),
    .miso_en   (miso_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; reg_addr = {3'b000, a}; wr_data = d;
    wait_clk(1);
    cs = 1'b0; write = 1'b0; reg_addr = '0; wr_data = '0;
  endtask

  task automatic frame_begin();
    spi_clk_in = m_cpol;
    wait_clk(HALF);
    ss_n_in = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    ss_n_in = 1'b1;
    wait_clk(HALF);
  endtask

  // Clear write timed to land on the edge where the completed byte reaches
  // the register block (3 clk after the last sample edge pin change).
  task automatic half_after_last(input bit clr);
    if (clr) begin
      wait_clk(3);
      bus_write(2'b00, 32'h3);
      wait_clk(HALF - 4);
    end else begin
      wait_clk(HALF);
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, input bit clr,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!m_cpha) begin
        mosi = mo[i];
        wait_clk(HALF);
        mi[i] = miso;
        spi_clk_in = ~m_cpol;
        half_after_last(clr && i == 0);
        spi_clk_in = m_cpol;
      end else begin
        spi_clk_in = ~m_cpol;
        mosi = mo[i];
        wait_clk(HALF);
        mi[i] = miso;
        spi_clk_in = m_cpol;
        half_after_last(clr && i == 0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 0; read = 0; write = 0; reg_addr = '0; wr_data = '0;
    spi_clk_in = 0; ss_n_in = 1; mosi = 0; m_cpol = 0; m_cpha = 0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=%h", rd_data, 32'h0); end
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", miso); end
    checks++; if (miso_en !== 1'b0) begin failures++; $display("FAIL reset_miso_en got=%b exp=0", miso_en); end
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    m_cpol = 0; m_cpha = 0;
    bus_write(2'b11, 32'hA5);
    checks++; if (rd_data !== 32'h400) begin failures++; $display("FAIL m0_txload got=%h exp=%h", rd_data, 32'h400); end
    frame_begin();
    checks++; if (rd_data !== 32'h800) begin failures++; $display("FAIL m0_busy got=%h exp=%h", rd_data, 32'h800); end
    checks++; if (miso_en !== 1'b1) begin failures++; $display("FAIL m0_miso_en got=%b exp=1", miso_en); end
    xfer(8'h3C, 8, 1'b0, mi);
    frame_end();
    checks++; if (mi !== 8'hA5) begin failures++; $display("FAIL m0_miso_byte got=%h exp=%h", mi, 8'hA5); end
    checks++; if (rd_data !== 32'h13C) begin failures++; $display("FAIL m0_rd got=%h exp=%h", rd_data, 32'h13C); end
  endtask

  task automatic test_mode3_overrun();
    logic [7:0] mi0, mi1;
    bus_write(2'b00, 32'h3);
    bus_write(2'b10, 32'h3);
    m_cpol = 1; m_cpha = 1;
    bus_write(2'b11, 32'h55);
    frame_begin();
    xfer(8'h81, 8, 1'b0, mi0);
    checks++; if (rd_data !== 32'h981) begin failures++; $display("FAIL m3_byte1_rd got=%h exp=%h", rd_data, 32'h981); end
    xfer(8'h7E, 8, 1'b0, mi1);
    frame_end();
    checks++; if (mi0 !== 8'h55) begin failures++; $display("FAIL m3_miso0 got=%h exp=%h", mi0, 8'h55); end
    checks++; if (mi1 !== 8'hFF) begin failures++; $display("FAIL m3_miso1 got=%h exp=%h", mi1, 8'hFF); end
    checks++; if (rd_data !== 32'h37E) begin failures++; $display("FAIL m3_overrun_rd got=%h exp=%h", rd_data, 32'h37E); end
  endtask

  task automatic test_clear_collision();
    logic [7:0] mi;
    bus_write(2'b00, 32'h3);
    checks++; if (rd_data !== 32'h7E) begin failures++; $display("FAIL clr_flags got=%h exp=%h", rd_data, 32'h7E); end
    bus_write(2'b10, 32'h2);
    m_cpol = 0; m_cpha = 1;
    frame_begin();
    xfer(8'h42, 8, 1'b1, mi);
    frame_end();
    checks++; if (rd_data !== 32'h142) begin failures++; $display("FAIL m1_clr_collide got=%h exp=%h", rd_data, 32'h142); end
    checks++; if (mi !== 8'hFF) begin failures++; $display("FAIL m1_miso_empty got=%h exp=%h", mi, 8'hFF); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    bus_write(2'b10, 32'h0);
    bus_write(2'b00, 32'h3);
    m_cpol = 0; m_cpha = 0;
    frame_begin();
    xfer(8'hB0, 5, 1'b0, mi);
    frame_end();
    checks++; if (rd_data !== 32'h42) begin failures++; $display("FAIL abort_rd got=%h exp=%h", rd_data, 32'h42); end
    checks++; if (miso_en !== 1'b0) begin failures++; $display("FAIL abort_miso_en got=%b exp=0", miso_en); end
    frame_begin();
    xfer(8'hC3, 8, 1'b0, mi);
    frame_end();
    checks++; if (rd_data !== 32'h1C3) begin failures++; $display("FAIL abort_next_rd got=%h exp=%h", rd_data, 32'h1C3); end
    checks++; if (mi !== 8'hFF) begin failures++; $display("FAIL abort_next_miso got=%h exp=%h", mi, 8'hFF); end
  endtask

  task automatic test_ctrl_busy();
    logic [7:0] mi;
    bus_write(2'b00, 32'h3);
    m_cpol = 0; m_cpha = 0;
    frame_begin();
    checks++; if (rd_data !== 32'h8C3) begin failures++; $display("FAIL busy_rd got=%h exp=%h", rd_data, 32'h8C3); end
    bus_write(2'b10, 32'h1);
    frame_end();
    frame_begin();
    xfer(8'h5A, 8, 1'b0, mi);
    frame_end();
    checks++; if (rd_data !== 32'h15A) begin failures++; $display("FAIL ctrl_ignored_rd got=%h exp=%h", rd_data, 32'h15A); end
    bus_write(2'b10, 32'h1);
    bus_write(2'b00, 32'h3);
    bus_write(2'b11, 32'h69);
    m_cpol = 1; m_cpha = 0;
    frame_begin();
    xfer(8'h96, 8, 1'b0, mi);
    frame_end();
    checks++; if (rd_data !== 32'h196) begin failures++; $display("FAIL ctrl_applied_rd got=%h exp=%h", rd_data, 32'h196); end
    checks++; if (mi !== 8'h69) begin failures++; $display("FAIL ctrl_applied_miso got=%h exp=%h", mi, 8'h69); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mode0();
    test_mode3_overrun();
    test_clear_collision();
    test_abort();
    test_ctrl_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
